// File: rtl/io_bus_arbiter_if.sv
// Signal bundle for io_bus_arbiter: requester-side ports plus the shared Wishbone-classic master port.
// master = arbiter view, slave = requesters and device fabric view.
interface io_bus_arbiter_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]      req_cyc_i;
  logic [NREQ-1:0]      req_stb_i;
  logic [NREQ-1:0]      req_we_i;
  logic [4*NREQ-1:0]    req_sel_i;
  logic [32*NREQ-1:0]   req_adr_i;
  logic [32*NREQ-1:0]   req_dat_i;
  logic [NREQ-1:0]      req_ack_o;
  logic [NREQ-1:0]      req_err_o;
  logic [31:0]          req_dat_o;
  logic [NREQ-1:0]      gnt_o;
  logic                 m_cyc_o;
  logic                 m_stb_o;
  logic                 m_we_o;
  logic [3:0]           m_sel_o;
  logic [31:0]          m_adr_o;
  logic [31:0]          m_dat_o;
  logic                 m_ack_i;
  logic                 m_stall_i;
  logic [31:0]          m_dat_i;

  modport master (
    input  req_cyc_i, req_stb_i, req_we_i, req_sel_i, req_adr_i, req_dat_i,
    output req_ack_o, req_err_o, req_dat_o, gnt_o,
    output m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o,
    input  m_ack_i, m_stall_i, m_dat_i
  );

  modport slave (
    output req_cyc_i, req_stb_i, req_we_i, req_sel_i, req_adr_i, req_dat_i,
    input  req_ack_o, req_err_o, req_dat_o, gnt_o,
    input  m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o,
    output m_ack_i, m_stall_i, m_dat_i
  );
endinterface

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter sharing one registered Wishbone-classic master port among NREQ requesters.
// Optional ack timeout with bus error is built when IOARB_TIMEOUT_EN is defined.
//
// state  | meaning
// IDLE   | no owner; arbitrate among cyc&stb requesters
// ACTIVE | owner's transaction is on the master port, waiting for m_ack_i
// ACKED  | ack (or error) held to owner until it drops stb
// LOCKED | owner keeps cyc high; grant held for the next access of its cycle
module io_bus_arbiter #(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  io_bus_arbiter_if.master bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("io_bus_arbiter: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, ACTIVE, ACKED, LOCKED} state_t;

  state_t            state;
  logic [PW-1:0]     last_q;
  logic [NREQ-1:0]   gnt_q;
  logic [NREQ-1:0]   ack_q;
  logic [31:0]       rdat_q;
  logic              m_cyc_q;
  logic              m_we_q;
  logic [3:0]        m_sel_q;
  logic [31:0]       m_adr_q;
  logic [31:0]       m_dat_q;

  logic [NREQ-1:0]   cand;
  logic              win_vld;
  logic [PW-1:0]     win_idx;
  logic              own_cyc;
  logic              own_stb;
  logic              tmo;
  logic              launch;
  logic [PW-1:0]     launch_idx;

  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int k);
    int j;
    j = int'(base) + k;
    if (j >= NREQ) j = j - NREQ;
    return PW'(j);
  endfunction

`ifdef IOARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0]     cnt_q;
  logic [NREQ-1:0]   err_q;
  assign tmo           = (cnt_q == CW'(TIMEOUT));
  assign bus.req_err_o = err_q;
`else
  assign tmo           = 1'b0;
  assign bus.req_err_o = '0;
`endif

  // last_q always names the owner while gnt_q is nonzero
  assign own_cyc = bus.req_cyc_i[last_q];
  assign own_stb = bus.req_stb_i[last_q];

  always_comb begin
    cand    = bus.req_cyc_i & bus.req_stb_i;
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!win_vld && cand[rr_idx(last_q, k)]) begin
        win_vld = 1'b1;
        win_idx = rr_idx(last_q, k);
      end
    end
  end

  always_comb begin
    launch     = 1'b0;
    launch_idx = last_q;
    unique case (state)
      IDLE: begin
        launch     = win_vld && !bus.m_stall_i && !bus.m_ack_i;
        launch_idx = win_idx;
      end
      LOCKED:  launch = own_cyc && own_stb && !bus.m_stall_i;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      last_q  <= PW'(NREQ - 1);
      gnt_q   <= '0;
      ack_q   <= '0;
      rdat_q  <= '0;
      m_cyc_q <= 1'b0;
      m_we_q  <= 1'b0;
      m_sel_q <= '0;
      m_adr_q <= '0;
      m_dat_q <= '0;
`ifdef IOARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= '0;
`endif
    end else begin
      if (launch) begin
        state   <= ACTIVE;
        last_q  <= launch_idx;
        gnt_q   <= ONE << launch_idx;
        m_cyc_q <= 1'b1;
        m_we_q  <= bus.req_we_i[launch_idx];
        m_sel_q <= bus.req_sel_i[4*launch_idx +: 4];
        m_adr_q <= bus.req_adr_i[32*launch_idx +: 32];
        m_dat_q <= bus.req_dat_i[32*launch_idx +: 32];
`ifdef IOARB_TIMEOUT_EN
        cnt_q   <= '0;
`endif
      end else begin
        unique case (state)
          IDLE: ;
          ACTIVE: begin
`ifdef IOARB_TIMEOUT_EN
            cnt_q <= cnt_q + 1'b1;
`endif
            if (bus.m_ack_i || tmo || !own_cyc) begin
              m_cyc_q <= 1'b0;
              m_we_q  <= 1'b0;
              m_sel_q <= '0;
              m_adr_q <= '0;
              m_dat_q <= '0;
            end
            // ack beats both timeout and a simultaneous owner abort
            if (bus.m_ack_i) begin
              ack_q  <= ONE << last_q;
              rdat_q <= bus.m_dat_i;
              state  <= ACKED;
            end else if (tmo) begin
              ack_q  <= ONE << last_q;
              rdat_q <= 32'hDEAD_DEAD;
`ifdef IOARB_TIMEOUT_EN
              err_q  <= ONE << last_q;
`endif
              state  <= ACKED;
            end else if (!own_cyc) begin
              gnt_q  <= '0;
              state  <= IDLE;
            end
          end
          ACKED: begin
            if (!own_stb) begin
              ack_q  <= '0;
              rdat_q <= '0;
`ifdef IOARB_TIMEOUT_EN
              err_q  <= '0;
`endif
              if (own_cyc) begin
                state <= LOCKED;
              end else begin
                gnt_q <= '0;
                state <= IDLE;
              end
            end
          end
          LOCKED: begin
            if (!own_cyc) begin
              gnt_q <= '0;
              state <= IDLE;
            end
          end
        endcase
      end
    end
  end

  assign bus.gnt_o     = gnt_q;
  assign bus.req_ack_o = ack_q;
  assign bus.req_dat_o = rdat_q;
  assign bus.m_cyc_o   = m_cyc_q;
  assign bus.m_stb_o   = m_cyc_q;
  assign bus.m_we_o    = m_we_q;
  assign bus.m_sel_o   = m_sel_q;
  assign bus.m_adr_o   = m_adr_q;
  assign bus.m_dat_o   = m_dat_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Bench for io_bus_arbiter: directed scenarios with literal expectations, then random traffic
// compared every cycle against a transaction-level model of owner/bus/ack behaviour.
module tb_io_bus_arbiter;
  localparam int NREQ    = 3;
  localparam int TIMEOUT = 16;

  logic clk_i = 1'b0;
  logic rst_i;
  int   checks   = 0;
  int   failures = 0;

  io_bus_arbiter_if #(.NREQ(NREQ)) bus ();

  io_bus_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  // Model: who owns the port, whether a transfer is on the bus, whether an ack is being held.
  typedef struct packed {
    logic        owned;
    int          owner;
    int          last;
    logic        busy;
    logic        hold;
    logic        err;
    logic [31:0] rdat;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] wdat;
    int          active_cycles;
  } mdl_t;

  mdl_t mdl;
  bit   chk_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic mdl_t take(input mdl_t s, input int c);
    mdl_t n = s;
    n.owned = 1'b1;
    n.owner = c;
    n.last  = c;
    n.busy  = 1'b1;
    n.active_cycles = 0;
    n.we   = bus.req_we_i[c];
    n.sel  = bus.req_sel_i[4*c +: 4];
    n.adr  = bus.req_adr_i[32*c +: 32];
    n.wdat = bus.req_dat_i[32*c +: 32];
    return n;
  endfunction

  function automatic mdl_t drop_xfer(input mdl_t s);
    mdl_t n = s;
    n.busy = 1'b0;
    n.we   = 1'b0;
    n.sel  = '0;
    n.adr  = '0;
    n.wdat = '0;
    return n;
  endfunction

  function automatic mdl_t mdl_next(input mdl_t s);
    mdl_t n = s;
    int o;
    if (rst_i) begin
      n = '0;
      n.last = NREQ - 1;
      return n;
    end
    o = s.owner;
    if (!s.owned) begin
      if (!bus.m_stall_i && !bus.m_ack_i) begin
        for (int k = 1; k <= NREQ; k++) begin
          int c = (s.last + k) % NREQ;
          if (!n.owned && bus.req_cyc_i[c] && bus.req_stb_i[c]) n = take(n, c);
        end
      end
    end else if (s.busy) begin
      n.active_cycles = s.active_cycles + 1;
      if (bus.m_ack_i) begin
        n = drop_xfer(n);
        n.hold = 1'b1;
        n.rdat = bus.m_dat_i;
`ifdef IOARB_TIMEOUT_EN
      end else if (s.active_cycles >= TIMEOUT) begin
        n = drop_xfer(n);
        n.hold = 1'b1;
        n.err  = 1'b1;
        n.rdat = 32'hDEAD_DEAD;
`endif
      end else if (!bus.req_cyc_i[o]) begin
        n = drop_xfer(n);
        n.owned = 1'b0;
      end
    end else if (s.hold) begin
      if (!bus.req_stb_i[o]) begin
        n.hold = 1'b0;
        n.err  = 1'b0;
        n.rdat = '0;
        if (!bus.req_cyc_i[o]) n.owned = 1'b0;
      end
    end else begin
      if (!bus.req_cyc_i[o]) n.owned = 1'b0;
      else if (bus.req_stb_i[o] && !bus.m_stall_i) n = take(n, o);
    end
    return n;
  endfunction

  function automatic logic [127:0] exp_ctl(input mdl_t s);
    logic [NREQ-1:0] oh;
    oh = s.owned ? (NREQ'(1) << s.owner) : '0;
    return {oh, (s.hold ? oh : '0), (s.err ? oh : '0), s.busy, s.busy, s.we, s.sel};
  endfunction

  always @(posedge clk_i) begin
    mdl    <= mdl_next(mdl);
    chk_en <= 1'b1;
  end

  always @(negedge clk_i) begin
    if (chk_en) begin
      check("ctl", {bus.gnt_o, bus.req_ack_o, bus.req_err_o, bus.m_cyc_o, bus.m_stb_o,
                    bus.m_we_o, bus.m_sel_o}, exp_ctl(mdl));
      check("data", {bus.m_adr_o, bus.m_dat_o, bus.req_dat_o}, {mdl.adr, mdl.wdat, mdl.rdat});
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int n, input logic c, input logic s, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
    bus.req_cyc_i[n]           = c;
    bus.req_stb_i[n]           = s;
    bus.req_we_i[n]            = w;
    bus.req_sel_i[4*n +: 4]    = 4'hF;
    bus.req_adr_i[32*n +: 32]  = a;
    bus.req_dat_i[32*n +: 32]  = d;
  endtask

  task automatic clear_all();
    bus.req_cyc_i = '0;
    bus.req_stb_i = '0;
    bus.m_ack_i   = 1'b0;
    bus.m_stall_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ngr;
    int waited;
    logic [NREQ-1:0] seq [4];
    logic [NREQ-1:0] exp_seq [4];
    logic prev_cyc;

    exp_seq[0] = 3'b001;
    exp_seq[1] = 3'b010;
    exp_seq[2] = 3'b100;
    exp_seq[3] = 3'b001;

    rst_i = 1'b1;
    clear_all();
    bus.req_we_i  = '0;
    bus.req_sel_i = '0;
    bus.req_adr_i = '0;
    bus.req_dat_i = '0;
    bus.m_dat_i   = '0;
    tick();
    tick();
    check("rst_outputs", {bus.gnt_o, bus.req_ack_o, bus.m_cyc_o, bus.m_adr_o, bus.req_dat_o}, '0);
    rst_i = 1'b0;

    // reset while ACTIVE; stale pointer would pick requester 2 next
    set_req(1, 1, 1, 0, 32'h0000_0100, 32'h0);
    tick();
    check("mid_gnt", bus.gnt_o, 3'b010);
    check("mid_cyc", bus.m_cyc_o, 1'b1);
    rst_i = 1'b1;
    set_req(1, 0, 0, 0, 32'h0, 32'h0);
    set_req(0, 1, 1, 0, 32'h0000_0200, 32'h0);
    set_req(2, 1, 1, 0, 32'h0000_0300, 32'h0);
    tick();
    check("mid_rst_out", {bus.gnt_o, bus.req_ack_o, bus.m_cyc_o, bus.m_adr_o}, '0);
    rst_i = 1'b0;
    tick();
    check("rst_rr_gnt", bus.gnt_o, 3'b001);
    clear_all();
    tick();
    tick();

    // single read from requester 1
    set_req(1, 1, 1, 0, 32'hFD00_0010, 32'h0);
    tick();
    check("rd_gnt", bus.gnt_o, 3'b010);
    check("rd_adr", bus.m_adr_o, 32'hFD00_0010);
    tick();
    check("rd_noack", bus.req_ack_o, 3'b000);
    bus.m_ack_i = 1'b1;
    bus.m_dat_i = 32'h1234_5678;
    tick();
    bus.m_ack_i = 1'b0;
    bus.m_dat_i = 32'h0;
    check("rd_ack", bus.req_ack_o, 3'b010);
    check("rd_dat", bus.req_dat_o, 32'h1234_5678);
    check("rd_cyc_off", bus.m_cyc_o, 1'b0);
    tick();
    check("rd_ack_held", bus.req_ack_o, 3'b010);
    set_req(1, 0, 0, 0, 32'h0, 32'h0);
    tick();
    check("rd_release", {bus.req_ack_o, bus.req_dat_o, bus.gnt_o}, '0);

    // contention with continuous single cycles
    do_reset();
    ngr = 0;
    prev_cyc = 1'b0;
    for (int t = 0; t < 60 && ngr < 4; t++) begin
      for (int n = 0; n < NREQ; n++) begin
        if (bus.req_ack_o[n]) set_req(n, 0, 0, 0, 32'h0, 32'h0);
        else                  set_req(n, 1, 1, 0, 32'h0000_1000 + n, 32'h0);
      end
      bus.m_ack_i = bus.m_cyc_o;
      tick();
      if (bus.m_cyc_o && !prev_cyc) begin
        seq[ngr] = bus.gnt_o;
        ngr++;
      end
      prev_cyc = bus.m_cyc_o;
    end
    check("rr_grant_count", ngr, 4);
    for (int i = 0; i < 4; i++) check("rr_seq", (i < ngr) ? seq[i] : 3'b000, exp_seq[i]);
    clear_all();
    tick();
    tick();
    tick();

    // read-modify-write under lock while requester 2 waits
    set_req(0, 1, 1, 0, 32'h0000_0300, 32'h0);
    tick();
    check("rmw_gnt_rd", bus.gnt_o, 3'b001);
    bus.m_ack_i = 1'b1;
    bus.m_dat_i = 32'hAAAA_5555;
    tick();
    bus.m_ack_i = 1'b0;
    check("rmw_rd_dat", bus.req_dat_o, 32'hAAAA_5555);
    set_req(2, 1, 1, 1, 32'h0000_0400, 32'h0000_0044);
    set_req(0, 1, 0, 0, 32'h0000_0300, 32'h0);
    tick();
    check("rmw_lock_gnt", {bus.gnt_o, bus.req_ack_o}, {3'b001, 3'b000});
    tick();
    check("rmw_lock_hold", {bus.gnt_o, bus.m_cyc_o}, {3'b001, 1'b0});
    set_req(0, 1, 1, 1, 32'h0000_0300, 32'hCAFE_0001);
    tick();
    check("rmw_wr_launch", {bus.gnt_o, bus.m_cyc_o, bus.m_we_o, bus.m_adr_o, bus.m_dat_o},
          {3'b001, 1'b1, 1'b1, 32'h0000_0300, 32'hCAFE_0001});
    bus.m_ack_i = 1'b1;
    tick();
    bus.m_ack_i = 1'b0;
    check("rmw_wr_ack", bus.req_ack_o, 3'b001);
    set_req(0, 0, 0, 0, 32'h0, 32'h0);
    tick();
    check("rmw_release", bus.gnt_o, 3'b000);
    tick();
    check("rmw_next_owner", {bus.gnt_o, bus.m_adr_o}, {3'b100, 32'h0000_0400});

    // abort by requester 2 while ACTIVE
    set_req(2, 0, 0, 0, 32'h0, 32'h0);
    tick();
    check("abort_clear", {bus.gnt_o, bus.req_ack_o, bus.m_cyc_o, bus.m_adr_o}, '0);
    tick();
    check("abort_no_ack", bus.req_ack_o, 3'b000);
    set_req(1, 1, 1, 0, 32'h0000_0500, 32'h0);
    tick();
    check("abort_back_idle", bus.gnt_o, 3'b010);
    clear_all();
    tick();
    tick();

    // device never acks
    set_req(1, 1, 1, 0, 32'h0000_0600, 32'h0);
    tick();
`ifdef IOARB_TIMEOUT_EN
    waited = 0;
    while (bus.req_err_o == '0 && waited < 200) begin
      tick();
      waited++;
    end
    check("tmo_wait", waited, TIMEOUT + 1);
    check("tmo_resp", {bus.req_ack_o, bus.req_err_o, bus.req_dat_o, bus.m_cyc_o},
          {3'b010, 3'b010, 32'hDEAD_DEAD, 1'b0});
    bus.m_ack_i = 1'b1;
    bus.m_dat_i = 32'h1111_2222;
    tick();
    bus.m_ack_i = 1'b0;
    check("tmo_late_ack", bus.req_dat_o, 32'hDEAD_DEAD);
`else
    waited = 0;
    for (int t = 0; t < 1100; t++) begin
      tick();
      if (bus.m_cyc_o && bus.req_ack_o == '0) waited++;
    end
    check("noack_hold", waited, 1100);
`endif
    clear_all();
    tick();
    tick();
    tick();

    // random traffic against the model
    for (int t = 0; t < 3000; t++) begin
      for (int n = 0; n < NREQ; n++) begin
        if ($urandom_range(0, 7) == 0) bus.req_cyc_i[n] = ~bus.req_cyc_i[n];
        bus.req_stb_i[n]          = bus.req_cyc_i[n] & ($urandom_range(0, 3) != 0);
        bus.req_we_i[n]           = 1'($urandom_range(0, 1));
        bus.req_sel_i[4*n +: 4]   = 4'($urandom_range(0, 15));
        bus.req_adr_i[32*n +: 32] = $urandom;
        bus.req_dat_i[32*n +: 32] = $urandom;
      end
      bus.m_ack_i   = ($urandom_range(0, 3) == 0);
      bus.m_stall_i = ($urandom_range(0, 3) == 0);
      bus.m_dat_i   = $urandom;
      rst_i         = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst_i = 1'b0;
    clear_all();
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
